// File: rtl/grayscale_pkg.sv
// Shared constants for the row-parallel RGB-to-luma converter.
// BT.601 integer coefficients and default geometry.
package grayscale_pkg;

  localparam int unsigned COLS_DEF  = 256;
  localparam int unsigned WIDTH_DEF = 8;

  // Coefficients sum to 1 << SHIFT so a gray input maps to itself.
  localparam int unsigned COEF_R = 77;
  localparam int unsigned COEF_G = 150;
  localparam int unsigned COEF_B = 29;
  localparam int unsigned ROUND  = 128;
  localparam int unsigned SHIFT  = 8;

endpackage

// File: rtl/grayscale_pixel.sv
// Combinational luma for one RGB pixel.
// Y = (77R + 150G + 29B + 128) >> 8, rounded to nearest.
module grayscale_pixel
  import grayscale_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  // One spare bit over 2*WIDTH holds the worst-case sum.
  localparam int unsigned SW = 2 * WIDTH + 1;

  localparam logic [SW-1:0] CR  = SW'(COEF_R);
  localparam logic [SW-1:0] CG  = SW'(COEF_G);
  localparam logic [SW-1:0] CB  = SW'(COEF_B);
  localparam logic [SW-1:0] RND = SW'(ROUND);

  logic [SW-1:0] r_ext;
  logic [SW-1:0] g_ext;
  logic [SW-1:0] b_ext;
  logic [SW-1:0] pr;
  logic [SW-1:0] pg;
  logic [SW-1:0] pb;
  logic [SW-1:0] sum;
  logic          unused_bits;

  assign r_ext = SW'(r_i);
  assign g_ext = SW'(g_i);
  assign b_ext = SW'(b_i);

  assign pr = CR * r_ext;
  assign pg = CG * g_ext;
  assign pb = CB * b_ext;

  assign sum = pr + pg + pb + RND;

  // The shift by WIDTH is just a bit-select of the sum.
  assign y_o = sum[2*WIDTH-1:WIDTH];

  // Top bit is always zero and low bits are dropped by rounding.
  assign unused_bits = ^{sum[SW-1], sum[WIDTH-1:0]};

endmodule

// File: rtl/grayscale.sv
// Row-parallel RGB to grayscale converter.
// One full row per cycle, one cycle latency, no handshake.
module grayscale
  import grayscale_pkg::*;
#(
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COLS*WIDTH*3-1:0] row_in,
  output logic [COLS*WIDTH-1:0]   row_out
);

  localparam int unsigned PW = 3 * WIDTH;

  logic [COLS*WIDTH-1:0] row_d;
  logic [COLS*WIDTH-1:0] row_q;

  // Pixel 0 lives in the MSBs of both rows.
  for (genvar k = 0; k < COLS; k++) begin : g_pix
    logic [PW-1:0] rgb;

    assign rgb = row_in[(COLS-1-k)*PW +: PW];

    grayscale_pixel #(
      .WIDTH (WIDTH)
    ) u_pix (
      .r_i (rgb[PW-1 -: WIDTH]),
      .g_i (rgb[2*WIDTH-1 -: WIDTH]),
      .b_i (rgb[WIDTH-1:0]),
      .y_o (row_d[(COLS-1-k)*WIDTH +: WIDTH])
    );
  end

  // Output row register; reset wins over the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row_out = row_q;

endmodule

// File: tb/tb_grayscale.sv
// Self-checking bench for grayscale.
// Random and directed rows against an arithmetic luma model.
module tb_grayscale;

  localparam int COLS = 256;
  localparam int W    = 8;
  localparam int IW   = COLS * W * 3;
  localparam int OW   = COLS * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] row_in = '0;
  logic [OW-1:0] row_out;

  int checks   = 0;
  int failures = 0;

  grayscale #(
    .COLS  (COLS),
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .row_out (row_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] luma(input int r, input int g,
                                      input int b);
    int y;
    y = (77 * r + 150 * g + 29 * b + 128) / 256;
    return y[7:0];
  endfunction

  function automatic logic [OW-1:0] model(input logic [IW-1:0] rin);
    logic [OW-1:0] o;
    logic [23:0]   p;
    o = '0;
    for (int k = 0; k < COLS; k++) begin
      p = rin[(COLS-1-k)*24 +: 24];
      o[(COLS-1-k)*8 +: 8] = luma(int'(p[23:16]), int'(p[15:8]),
                                  int'(p[7:0]));
    end
    return o;
  endfunction

  function automatic int first_diff(input logic [OW-1:0] a,
                                    input logic [OW-1:0] b);
    for (int k = 0; k < COLS; k++)
      if (a[(COLS-1-k)*8 +: 8] !== b[(COLS-1-k)*8 +: 8]) return k;
    return 0;
  endfunction

  function automatic logic [IW-1:0] rand_row();
    logic [IW-1:0] r;
    for (int i = 0; i < IW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] e;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      row_in = rand_row();
      step();
      checks++;
      if (row_out !== '0) begin
        failures++;
        $display("FAIL reset cyc%0d pix%0d got %h want 00", c,
                 first_diff(row_out, '0),
                 row_out[(COLS-1-first_diff(row_out, '0))*8 +: 8]);
      end
    end
    rst = 1'b0;
    row_in = '1;
    e = '1;
    step();
    checks++;
    if (row_out !== e) begin
      failures++;
      $display("FAIL reset_release pix%0d got %h want ff",
               first_diff(row_out, e),
               row_out[(COLS-1-first_diff(row_out, e))*8 +: 8]);
    end
  endtask

  task automatic test_primaries();
    logic [7:0] want [4];
    logic [7:0] got;
    want = '{8'd77, 8'd149, 8'd29, 8'd128};
    row_in = '0;
    row_in[(COLS-1)*24 +: 24] = 24'hFF0000;
    row_in[(COLS-2)*24 +: 24] = 24'h00FF00;
    row_in[(COLS-3)*24 +: 24] = 24'h0000FF;
    row_in[(COLS-4)*24 +: 24] = 24'h808080;
    step();
    for (int k = 0; k < 4; k++) begin
      got = row_out[(COLS-1-k)*8 +: 8];
      checks++;
      if (got !== want[k]) begin
        failures++;
        $display("FAIL primary pix%0d got %0d want %0d", k, got,
                 want[k]);
      end
    end
    checks++;
    if (row_out[(COLS-4)*8-1:0] !== '0) begin
      failures++;
      $display("FAIL primary_rest nonzero above pix3");
    end
  endtask

  task automatic test_ordering();
    logic [7:0] kk;
    logic [7:0] got;
    int         bad;
    bad = 0;
    for (int k = 0; k < COLS; k++) begin
      kk = 8'(k);
      row_in[(COLS-1-k)*24 +: 24] = {kk, kk, kk};
    end
    step();
    for (int k = 0; k < COLS; k++) begin
      kk  = 8'(k);
      got = row_out[(COLS-1-k)*8 +: 8];
      checks++;
      if (got !== kk) begin
        failures++;
        if (bad++ < 4)
          $display("FAIL ordering pix%0d got %0d want %0d", k, got, kk);
      end
    end
  endtask

  task automatic test_hold();
    logic [OW-1:0] e;
    row_in = rand_row();
    e = model(row_in);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (row_out !== e) begin
        failures++;
        $display("FAIL hold cyc%0d pix%0d", c, first_diff(row_out, e));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] rows [3];
    logic [OW-1:0] e;
    for (int i = 0; i < 3; i++) rows[i] = rand_row();
    for (int i = 0; i < 3; i++) begin
      row_in = rows[i];
      step();
      e = model(rows[i]);
      checks++;
      if (row_out !== e) begin
        failures++;
        $display("FAIL stream row%0d pix%0d got %h want %h", i,
                 first_diff(row_out, e),
                 row_out[(COLS-1-first_diff(row_out, e))*8 +: 8],
                 e[(COLS-1-first_diff(row_out, e))*8 +: 8]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic [IW-1:0] c;
    logic [OW-1:0] e;
    a = rand_row();
    b = rand_row();
    c = rand_row();
    row_in = a;
    step();
    e = model(a);
    checks++;
    if (row_out !== e) begin
      failures++;
      $display("FAIL midrst_a pix%0d", first_diff(row_out, e));
    end
    row_in = b;
    rst = 1'b1;
    step();
    checks++;
    if (row_out !== '0) begin
      failures++;
      $display("FAIL midrst_b pix%0d not zero", first_diff(row_out, '0));
    end
    rst = 1'b0;
    row_in = c;
    step();
    e = model(c);
    checks++;
    if (row_out !== e) begin
      failures++;
      $display("FAIL midrst_c pix%0d", first_diff(row_out, e));
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] e;
    int            k;
    for (int n = 0; n < 1000; n++) begin
      row_in = rand_row();
      e = model(row_in);
      step();
      checks++;
      if (row_out !== e) begin
        failures++;
        k = first_diff(row_out, e);
        $display("FAIL random row%0d pix%0d got %h want %h", n, k,
                 row_out[(COLS-1-k)*8 +: 8], e[(COLS-1-k)*8 +: 8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_primaries();
    test_ordering();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
